faxi_mst_lte: RTL and testbench
===============================

# faxi_mst_lte

AXI4-Lite initiator that drives the FPU co-processor register slave. It sits on the host side of the co-processor's AXI-Lite link and accepts one FPU job at a time on a valid/ready command port. For each job it writes OPERAND1, OPERAND2 and FRM_OP, waits a fixed settle time, then reads FCS (flags) and FRES (result). It returns result, flags and an error bit on a valid/ready response port.

## Interface
- OPERAND_WIDTH, 32, FPU operand/result width
- BASE_ADDR, 32'h0000_0000, register-file base; registers are word-indexed at BASE_ADDR+0..+4 (step 1)
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width
- WAIT_CYCLES, 4, idle cycles between the last write and the first read (≥1)
- TIMEOUT_CYCLES, 256, maximum cycles a request waits for its B/R handshake
- aclk  in  1  clock; single clock domain
- arst  in  1  reset; synchronous, active-high
- cmd_valid_i / cmd_ready_o  in/out  1  job handshake
- cmd_opa_i, cmd_opb_i  in  OPERAND_WIDTH  operands
- cmd_frm_op_i  in  DATA_WIDTH  rounding-mode/opcode word
- rsp_valid_o / rsp_ready_i  out/in  1  result handshake
- rsp_result_o  out  OPERAND_WIDTH  FRES readback
- rsp_flag_o  out  5  FCS[4:0] readback
- rsp_err_o  out  1  any non-OKAY response or timeout in this job
- awvalid_o out 1, awaddr_o out ADDR_WIDTH, awready_i in 1
- wvalid_o out 1, wdata_o out DATA_WIDTH, wstrb_o out STRB_WIDTH, wready_i in 1
- bvalid_i in 1, bresp_i in 2, bready_o out 1
- arvalid_o out 1, araddr_o out ADDR_WIDTH, arready_i in 1
- rvalid_i in 1, rdata_i in DATA_WIDTH, rresp_i in 2, rready_o out 1

## Operation
- States: IDLE, WR_REQ, WR_GAP, WAIT, RD_REQ, RD_GAP, RSP. A 3-bit index idx selects the register.
- IDLE:
  - cmd_ready_o=1, combinational on state.
  - On cmd_valid_i, latch opa/opb/frm_op, clear err, set idx=0, and go to WR_REQ.
- WR_REQ:
  - awvalid_o=wvalid_o=1 together; awaddr_o=BASE_ADDR+idx; wdata_o=opa/opb/frm_op for idx 0/1/2; wstrb_o all ones; bready_o=1.
  - awvalid_o and wvalid_o stay high until the B handshake (bvalid_i&bready_o), regardless of awready_i/wready_i. The slave requires both valids held through its response phase.
  - On the B handshake: err|=(bresp_i!=0); go to WR_GAP.
- WR_GAP:
  - One cycle with all valids low.
  - Then idx++. If idx was 2, go to WAIT and load the wait counter; otherwise go to WR_REQ.
- WAIT: count WAIT_CYCLES cycles, then idx=3 and go to RD_REQ.
- RD_REQ:
  - arvalid_o=1, araddr_o=BASE_ADDR+idx, rready_o=1; held until rvalid_i.
  - On the R handshake: err|=(rresp_i!=0). Capture rdata_i[4:0] into the flag register (idx 3) or rdata_i into the result register (idx 4).
  - Go to RD_GAP.
- RD_GAP: one idle cycle. If idx was 3, set idx=4 and go to RD_REQ; otherwise go to RSP.
- RSP: rsp_valid_o=1 with stable data until rsp_ready_i, then go to IDLE.
- Timeout:
  - A counter clears on entry to WR_REQ/RD_REQ.
  - If it reaches TIMEOUT_CYCLES-1 without a handshake: drop all valids, err=1, and jump to RSP. Result/flag registers keep the values captured so far.
- cmd_valid_i outside IDLE is ignored. rsp_ready_i outside RSP is ignored.

## Timing
- All AXI outputs, rsp_* and state are registered. Valids fall on the same edge that samples the handshake.
- Reset (arst=1 at a clock edge):
  - state=IDLE, idx=0, counters=0.
  - All valid/ready AXI outputs 0; awaddr/araddr/wdata 0; wstrb 0.
  - rsp_valid_o=0, rsp_result_o=0, rsp_flag_o=0, rsp_err_o=0; cmd_ready_o=1.
- Reset mid-transaction aborts immediately. No completion is owed to the slave.
- Against the FPU slave:
  - Each write takes 4 cycles and each read takes 3 cycles, each followed by 1 gap cycle.
  - With WAIT_CYCLES=4, cmd handshake in cycle 0 gives rsp_valid_o high in cycle 28.
- rsp_valid_o and rsp_ready_i high in the same cycle: accept, IDLE next cycle, cmd_ready_o=1 in that cycle.
- Back-to-back jobs: minimum one IDLE cycle between rsp handshake and the next cmd handshake.

## Structure
- Package faxi_pkg holds:
  - state encoding;
  - register offsets OFS_OPA=0, OFS_OPB=1, OFS_FRM_OP=2, OFS_FCS=3, OFS_FRES=4;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- Single module, no sub-modules. The wait and timeout counters share one down-counter.

## Test plan
- Against the FPU slave with a stub FPU: opa=32'h3F800000, opb=32'h40000000, frm_op=32'h1; the stub returns result 32'h40400000 and flags 5'h01 → slave regs 0..2 hold the written words, rsp_result_o=32'h40400000, rsp_flag_o=5'h01, rsp_err_o=0, rsp_valid_o in cycle 28.
- Slave model answers bresp=2'b10 on the second write → sequence completes, rsp_err_o=1, the read data is still returned.
- Slave never asserts rvalid on the FCS read, TIMEOUT_CYCLES=16 → arvalid_o drops after 16 cycles, rsp_valid_o=1, rsp_err_o=1, rsp_result_o=0.
- rsp_ready_i held low for 10 cycles → rsp_* stable for the whole hold, cmd_ready_o=0, a cmd_valid_i pulse is ignored; then handshake → IDLE.
- arst asserted during WR_REQ of the second write → next cycle all valids 0, cmd_ready_o=1, rsp_err_o=0; a new job then completes normally.

Source files
------------

// File: rtl/faxi_pkg.sv
// Shared definitions for the FPU AXI4-Lite initiator: FSM encoding,
// register offsets in the co-processor register file and AXI response codes.
package faxi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_REQ = 3'd1,
    ST_WR_GAP = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RD_REQ = 3'd4,
    ST_RD_GAP = 3'd5,
    ST_RSP    = 3'd6
  } state_t;

  localparam logic [2:0] OFS_OPA    = 3'd0;
  localparam logic [2:0] OFS_OPB    = 3'd1;
  localparam logic [2:0] OFS_FRM_OP = 3'd2;
  localparam logic [2:0] OFS_FCS    = 3'd3;
  localparam logic [2:0] OFS_FRES   = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/faxi_mst_lte_if.sv
// AXI4-Lite link between the initiator and the FPU register slave.
interface faxi_mst_lte_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  awvalid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awready;
  logic                  wvalid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wready;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic                  bready;
  logic                  arvalid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/faxi_mst_lte.sv
// Single-job AXI4-Lite initiator: writes OPA/OPB/FRM_OP, waits, reads FCS and FRES,
// then presents result, flags and a sticky error bit on the response port.
module faxi_mst_lte
  import faxi_pkg::*;
#(
  parameter int                    OPERAND_WIDTH  = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    STRB_WIDTH     = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    WAIT_CYCLES    = 4,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [OPERAND_WIDTH-1:0] cmd_opa_i,
  input  logic [OPERAND_WIDTH-1:0] cmd_opb_i,
  input  logic [DATA_WIDTH-1:0]    cmd_frm_op_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [OPERAND_WIDTH-1:0] rsp_result_o,
  output logic [4:0]               rsp_flag_o,
  output logic                     rsp_err_o,
  faxi_mst_lte_if.master           axi
);

  localparam int CNT_MAX = (WAIT_CYCLES > TIMEOUT_CYCLES) ? WAIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t                   state_reg;
  logic [2:0]               idx_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [OPERAND_WIDTH-1:0] opa_reg;
  logic [OPERAND_WIDTH-1:0] opb_reg;
  logic [DATA_WIDTH-1:0]    frm_reg;
  logic [OPERAND_WIDTH-1:0] result_reg;
  logic [4:0]               flag_reg;
  logic                     err_reg;
  logic                     rsp_valid_reg;

  assign cmd_ready_o  = (state_reg == ST_IDLE);
  assign rsp_valid_o  = rsp_valid_reg;
  assign rsp_result_o = result_reg;
  assign rsp_flag_o   = flag_reg;
  assign rsp_err_o    = err_reg;

  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [2:0] ofs);
    return BASE_ADDR + ADDR_WIDTH'(ofs);
  endfunction

  // The shared down-counter is reloaded with the timeout budget on every request
  // entry; reaching zero without a handshake aborts the job into RSP.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      opa_reg       <= '0;
      opb_reg       <= '0;
      frm_reg       <= '0;
      result_reg    <= '0;
      flag_reg      <= '0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      axi.awvalid   <= 1'b0;
      axi.awaddr    <= '0;
      axi.wvalid    <= 1'b0;
      axi.wdata     <= '0;
      axi.wstrb     <= '0;
      axi.bready    <= 1'b0;
      axi.arvalid   <= 1'b0;
      axi.araddr    <= '0;
      axi.rready    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            opa_reg     <= cmd_opa_i;
            opb_reg     <= cmd_opb_i;
            frm_reg     <= cmd_frm_op_i;
            result_reg  <= '0;
            flag_reg    <= '0;
            err_reg     <= 1'b0;
            idx_reg     <= OFS_OPA;
            cnt_reg     <= TO_LOAD;
            axi.awvalid <= 1'b1;
            axi.wvalid  <= 1'b1;
            axi.bready  <= 1'b1;
            axi.awaddr  <= reg_addr(OFS_OPA);
            axi.wdata   <= DATA_WIDTH'(cmd_opa_i);
            axi.wstrb   <= {STRB_WIDTH{1'b1}};
            state_reg   <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (axi.bvalid && axi.bready) begin
            err_reg     <= err_reg | (axi.bresp != RESP_OKAY);
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            state_reg   <= ST_WR_GAP;
          end else if (cnt_reg == '0) begin
            axi.awvalid   <= 1'b0;
            axi.wvalid    <= 1'b0;
            axi.bready    <= 1'b0;
            err_reg       <= 1'b1;
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RSP;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_WR_GAP: begin
          idx_reg <= idx_reg + 3'd1;
          if (idx_reg == OFS_FRM_OP) begin
            cnt_reg   <= WAIT_LOAD;
            state_reg <= ST_WAIT;
          end else begin
            cnt_reg     <= TO_LOAD;
            axi.awvalid <= 1'b1;
            axi.wvalid  <= 1'b1;
            axi.bready  <= 1'b1;
            axi.awaddr  <= reg_addr(idx_reg + 3'd1);
            axi.wdata   <= (idx_reg == OFS_OPA) ? DATA_WIDTH'(opb_reg) : frm_reg;
            state_reg   <= ST_WR_REQ;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            idx_reg     <= OFS_FCS;
            cnt_reg     <= TO_LOAD;
            axi.arvalid <= 1'b1;
            axi.rready  <= 1'b1;
            axi.araddr  <= reg_addr(OFS_FCS);
            state_reg   <= ST_RD_REQ;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_RD_REQ: begin
          if (axi.rvalid && axi.rready) begin
            err_reg <= err_reg | (axi.rresp != RESP_OKAY);
            if (idx_reg == OFS_FCS) flag_reg <= axi.rdata[4:0];
            else                    result_reg <= OPERAND_WIDTH'(axi.rdata);
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            state_reg   <= ST_RD_GAP;
          end else if (cnt_reg == '0) begin
            axi.arvalid   <= 1'b0;
            axi.rready    <= 1'b0;
            err_reg       <= 1'b1;
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RSP;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_RD_GAP: begin
          if (idx_reg == OFS_FCS) begin
            idx_reg     <= OFS_FRES;
            cnt_reg     <= TO_LOAD;
            axi.arvalid <= 1'b1;
            axi.rready  <= 1'b1;
            axi.araddr  <= reg_addr(OFS_FRES);
            state_reg   <= ST_RD_REQ;
          end else begin
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_faxi_mst_lte.sv
// Bench for faxi_mst_lte: FPU register-slave model with stubbed FCS/FRES,
// scoreboard of expected responses, latency, error, timeout, hold and reset checks.
module tb_faxi_mst_lte;
  import faxi_pkg::*;

  logic        aclk = 1'b0;
  logic        arst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] cmd_opa, cmd_opb, cmd_frm_op, rsp_result;
  logic [4:0]  rsp_flag;

  always #5 aclk = ~aclk;

  faxi_mst_lte_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  faxi_mst_lte #(
    .OPERAND_WIDTH(32), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
    .BASE_ADDR(32'h0), .WAIT_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .arst(arst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_opa_i(cmd_opa), .cmd_opb_i(cmd_opb), .cmd_frm_op_i(cmd_frm_op),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_flag_o(rsp_flag), .rsp_err_o(rsp_err),
    .axi(axi)
  );

  // Slave model: 4-cycle writes, 3-cycle reads; FCS/FRES come from the stub FPU.
  logic [31:0] sregs [0:3];
  logic [31:0] stub_result, stub_flags, berr_addr;
  bit          hang_fcs;
  int          wcnt, rcnt, cyc, arv_run, last_arv_run;

  always_ff @(posedge aclk) begin
    cyc <= cyc + 1;
    if (axi.arvalid) arv_run <= arv_run + 1;
    else if (arv_run != 0) begin
      last_arv_run <= arv_run;
      arv_run      <= 0;
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
      axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= 2'b00;
      wcnt <= 0; rcnt <= 0;
    end else begin
      axi.awready <= 1'b0; axi.wready <= 1'b0; axi.arready <= 1'b0;
      if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0; wcnt <= 0;
      end else if (axi.awvalid && axi.wvalid && !axi.bvalid) begin
        wcnt <= wcnt + 1;
        if (wcnt == 1) begin axi.awready <= 1'b1; axi.wready <= 1'b1; end
        if (wcnt == 2) begin
          axi.bvalid <= 1'b1;
          axi.bresp  <= (axi.awaddr == berr_addr) ? RESP_SLVERR : RESP_OKAY;
          if (axi.awaddr < 32'd3) sregs[axi.awaddr[1:0]] <= axi.wdata;
        end
      end else wcnt <= 0;
      if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0; rcnt <= 0;
      end else if (axi.arvalid && !axi.rvalid) begin
        rcnt <= rcnt + 1;
        if (rcnt == 0) axi.arready <= 1'b1;
        if (rcnt == 1 && !(hang_fcs && axi.araddr == 32'd3)) begin
          axi.rvalid <= 1'b1;
          axi.rresp  <= RESP_OKAY;
          axi.rdata  <= (axi.araddr == 32'd3) ? stub_flags :
                        (axi.araddr == 32'd4) ? stub_result : sregs[axi.araddr[1:0]];
        end
      end else rcnt <= 0;
    end
  end

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flag;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int job_no   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drives one job, pushes its expectation, then pops and checks it at the response.
  task automatic run_job(input logic [31:0] opa, input logic [31:0] opb, input logic [31:0] frm,
                         input exp_t exp, input bit chk_lat, input int hold);
    int   n, c0, c1;
    exp_t e;
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check_eq("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_opa = opa; cmd_opb = opb; cmd_frm_op = frm; cmd_valid = 1'b1;
    sb.push_back(exp);
    c0 = cyc;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 300) begin tick(); n++; end
    check_eq("rsp_valid_wait", rsp_valid, 1'b1);
    c1 = cyc;
    if (chk_lat) check_eq("latency", 64'(c1 - c0), 64'd28);
    check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check_eq("rsp_result", rsp_result, e.result);
    check_eq("rsp_flag", rsp_flag, e.flag);
    check_eq("rsp_err", rsp_err, e.err);
    $display("job %0d: opa=%h opb=%h frm=%h -> result=%h flag=%h err=%b latency=%0d",
             job_no, opa, opb, frm, rsp_result, rsp_flag, rsp_err, c1 - c0);
    job_no++;
    for (int h = 0; h < hold; h++) begin
      if (h == 3) begin
        cmd_valid = 1'b1; cmd_opa = 32'hDEAD_BEEF;
      end
      if (h == 4) cmd_valid = 1'b0;
      tick();
      check_eq("hold_valid", rsp_valid, 1'b1);
      check_eq("hold_result", rsp_result, e.result);
      check_eq("hold_flag", rsp_flag, e.flag);
      check_eq("hold_err", rsp_err, e.err);
      check_eq("hold_cmd_ready", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("post_rsp_valid", rsp_valid, 1'b0);
    check_eq("post_cmd_ready", cmd_ready, 1'b1);
    tick();
    check_eq("post_awvalid", axi.awvalid, 1'b0);
  endtask

  initial begin
    int n;
    arst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opa = '0; cmd_opb = '0; cmd_frm_op = '0;
    stub_result = 32'h4040_0000; stub_flags = 32'hFFFF_FFE1;
    berr_addr = 32'hFFFF_FFFF; hang_fcs = 1'b0;
    repeat (3) tick();
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_result", rsp_result, 32'h0);
    check_eq("rst_err", rsp_err, 1'b0);
    check_eq("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
    check_eq("rst_wstrb", axi.wstrb, 4'h0);
    arst = 1'b0;
    tick();

    // Nominal job: flags readback must keep only FCS[4:0].
    run_job(32'h3F80_0000, 32'h4000_0000, 32'h1, '{32'h4040_0000, 5'h01, 1'b0}, 1'b1, 0);
    check_eq("slv_reg0", sregs[0], 32'h3F80_0000);
    check_eq("slv_reg1", sregs[1], 32'h4000_0000);
    check_eq("slv_reg2", sregs[2], 32'h0000_0001);

    // SLVERR on the second write: job completes, data still returned.
    berr_addr = 32'd1; stub_result = 32'hC0A0_0000; stub_flags = 32'h0000_0014;
    run_job(32'h1234_5678, 32'h9ABC_DEF0, 32'h3, '{32'hC0A0_0000, 5'h14, 1'b1}, 1'b1, 0);
    berr_addr = 32'hFFFF_FFFF;

    // FCS read never answered: arvalid for exactly 16 cycles, then error response.
    hang_fcs = 1'b1;
    run_job(32'h1, 32'h2, 32'h4, '{32'h0, 5'h0, 1'b1}, 1'b0, 0);
    check_eq("timeout_arvalid_len", 64'(last_arv_run), 64'd16);
    hang_fcs = 1'b0;

    // Response held for 10 cycles with a stray command pulse in the middle.
    stub_result = 32'h3F00_0000; stub_flags = 32'h0000_0008;
    run_job(32'hAAAA_5555, 32'h5555_AAAA, 32'h2, '{32'h3F00_0000, 5'h08, 1'b0}, 1'b1, 10);

    // Reset during the second write request, then a clean job.
    cmd_opa = 32'h1111_1111; cmd_opb = 32'h2222_2222; cmd_frm_op = 32'h0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!(axi.awvalid && axi.awaddr == 32'd1) && n < 100) begin tick(); n++; end
    check_eq("reach_wr2", {axi.awvalid, axi.awaddr}, {1'b1, 32'd1});
    arst = 1'b1;
    tick();
    arst = 1'b0;
    check_eq("mid_rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid}, 4'b0);
    check_eq("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("mid_rst_err", rsp_err, 1'b0);
    stub_result = 32'h4110_0000; stub_flags = 32'h0000_0002;
    run_job(32'h4100_0000, 32'h3F00_0000, 32'h0, '{32'h4110_0000, 5'h02, 1'b0}, 1'b1, 0);
    check_eq("final_reg1", sregs[1], 32'h3F00_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
